// File: rtl/tc_pkg.sv
// Shared types, constants and the narrowing helper for the forward 4x4 transform.
// Build option FWDTRAN_SAT_EN: narrowing saturates instead of wrapping.
package tc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROW  = 2'd1,
        COL  = 2'd2,
        DONE = 2'd3
    } tc_state_e;

    // Extra bits above the sample MSB so a 1-D pass can never overflow internally.
    localparam int TC_GUARD_BITS = 4;

    // Fit a value into msb+1 signed bits; the result stays sign-extended to 32 bits.
    function automatic logic signed [31:0] tc_narrow(input logic signed [31:0] value,
                                                     input int msb);
`ifdef FWDTRAN_SAT_EN
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< msb) - 32'sd1;
        lo = -(32'sd1 <<< msb);
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
`else
        return (value <<< (31 - msb)) >>> (31 - msb);
`endif
    endfunction

endpackage

// File: rtl/fwdtran_butterfly4.sv
// Combinational 4-point forward core-transform butterfly, shared by row and column passes.
module fwdtran_butterfly4 #(
    parameter int W = 19
) (
    input  logic signed [W-1:0] x0_i,
    input  logic signed [W-1:0] x1_i,
    input  logic signed [W-1:0] x2_i,
    input  logic signed [W-1:0] x3_i,
    output logic signed [W-1:0] y0_o,
    output logic signed [W-1:0] y1_o,
    output logic signed [W-1:0] y2_o,
    output logic signed [W-1:0] y3_o
);

    logic signed [W-1:0] s0;
    logic signed [W-1:0] s1;
    logic signed [W-1:0] d0;
    logic signed [W-1:0] d1;

    assign s0 = x0_i + x3_i;
    assign s1 = x1_i + x2_i;
    assign d0 = x0_i - x3_i;
    assign d1 = x1_i - x2_i;

    assign y0_o = s0 + s1;
    assign y1_o = (d0 <<< 1) + d1;
    assign y2_o = s0 - s1;
    assign y3_o = d0 - (d1 <<< 1);

endmodule

// File: rtl/fwdtran_4x4.sv
// Time-multiplexed forward 4x4 integer transform: 4 row passes, then 4 column passes.
// Build option FWDTRAN_SAT_EN selects saturating narrowing (default wraps).
module fwdtran_4x4
    import tc_pkg::*;
#(
    parameter int BIT_LENGTH = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [BIT_LENGTH:0]   residuals   [16],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [BIT_LENGTH:0]   transformed [16]
);

    localparam int SW = BIT_LENGTH + 1;
    localparam int IW = BIT_LENGTH + TC_GUARD_BITS;

    tc_state_e             state_q;
    logic [1:0]            k_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic signed [SW-1:0]  a_q   [16];
    logic signed [SW-1:0]  b_q   [16];
    logic signed [SW-1:0]  out_q [16];

    logic signed [IW-1:0]  bf_x  [4];
    logic signed [IW-1:0]  bf_y  [4];
    logic signed [SW-1:0]  nar   [4];

    // Row pass reads row k of A; column pass reads column k of B.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] GI = 2'(gi);
        assign bf_x[gi] = IW'((state_q == COL) ? b_q[{GI, k_q}] : a_q[{k_q, GI}]);
        assign nar[gi]  = SW'(tc_narrow(32'(bf_y[gi]), BIT_LENGTH));
    end

    fwdtran_butterfly4 #(
        .W (IW)
    ) u_bf (
        .x0_i (bf_x[0]),
        .x1_i (bf_x[1]),
        .x2_i (bf_x[2]),
        .x3_i (bf_x[3]),
        .y0_o (bf_y[0]),
        .y1_o (bf_y[1]),
        .y2_o (bf_y[2]),
        .y3_o (bf_y[3])
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= 2'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                out_q[i] <= '0;
            end
        end else if (enable) begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        for (int i = 0; i < 16; i++) begin
                            a_q[i] <= residuals[i];
                        end
                        k_q        <= 2'd0;
                        in_ready_q <= 1'b0;
                        state_q    <= ROW;
                    end
                end
                ROW: begin
                    for (int i = 0; i < 4; i++) begin
                        b_q[{k_q, 2'(i)}] <= nar[i];
                    end
                    k_q <= k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        state_q <= COL;
                    end
                end
                COL: begin
                    for (int i = 0; i < 4; i++) begin
                        out_q[{2'(i), k_q}] <= nar[i];
                    end
                    k_q <= k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // Re-arm in_ready on the way out so the next block lands one cycle later.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign transformed = out_q;

endmodule

// File: tb/tb_fwdtran_4x4.sv
// Directed bench for fwdtran_4x4: a 16-bit instance plus a 12-bit instance for narrowing.
module tb_fwdtran_4x4;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic               in_valid;
    logic               out_ready;
    logic               in_ready15, out_valid15, in_ready11, out_valid11;
    logic signed [15:0] res15 [16];
    logic signed [15:0] tr15  [16];
    logic signed [11:0] res11 [16];
    logic signed [11:0] tr11  [16];

    int tests = 0;
    int fails = 0;
    int cyc_cnt = 0;
    int acc_q[$];

    always #5 clk = ~clk;

    fwdtran_4x4 #(.BIT_LENGTH(15)) dut15 (
        .clk (clk), .reset (reset), .enable (enable),
        .in_valid (in_valid), .in_ready (in_ready15), .residuals (res15),
        .out_valid (out_valid15), .out_ready (out_ready), .transformed (tr15)
    );

    fwdtran_4x4 #(.BIT_LENGTH(11)) dut11 (
        .clk (clk), .reset (reset), .enable (enable),
        .in_valid (in_valid), .in_ready (in_ready11), .residuals (res11),
        .out_valid (out_valid11), .out_ready (out_ready), .transformed (tr11)
    );

    // Log every accept of the 16-bit instance by cycle number.
    always @(posedge clk) begin
        if (!reset && enable && in_valid && in_ready15) begin
            acc_q.push_back(cyc_cnt);
        end
        cyc_cnt <= cyc_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("[TB] check %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic load(input int v[16]);
        for (int i = 0; i < 16; i++) begin
            res15[i] = 16'(v[i]);
            res11[i] = 12'(v[i]);
        end
    endtask

    task automatic accept();
        int n;
        n = 0;
        in_valid = 1'b1;
        while (!in_ready15 && n < 50) begin
            tick();
            n++;
        end
        check("accept_ready", in_ready15, 1);
        tick();
        in_valid = 1'b0;
    endtask

    // Returns the cycle index (accept cycle = 0) at which out_valid is first seen.
    task automatic wait_done(input int start, output int cyc);
        cyc = start;
        while (!out_valid15 && cyc < 60) begin
            tick();
            cyc++;
        end
    endtask

    task automatic check_block(input string tag, input int exp[16]);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s[%0d]", tag, i), tr15[i], exp[i]);
        end
    endtask

    task automatic release_block();
        out_ready = 1'b1;
        tick();
        check("release_out_valid", out_valid15, 0);
        out_ready = 1'b0;
    endtask

    // Direct matrix product Cf*X*Cf^T.
    function automatic void model(input int x[16], output int y[16]);
        int c [4][4];
        c = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                y[4*i+j] = 0;
                for (int a = 0; a < 4; a++) begin
                    for (int b = 0; b < 4; b++) begin
                        y[4*i+j] += c[i][a] * x[4*a+b] * c[j][b];
                    end
                end
            end
        end
    endfunction

    initial begin
        int zeros [16];
        int ones [16];
        int imp [16];
        int imp_exp [16];
        int ramp [16];
        int ramp2 [16];
        int big [16];
        int exp [16];
        int cyc;
        int n;
        logic signed [31:0] exp11;

        for (int i = 0; i < 16; i++) begin
            zeros[i] = 0;
            ones[i]  = 1;
            imp[i]   = (i == 0) ? 1 : 0;
            ramp[i]  = i - 7;
            ramp2[i] = ((i * 37) % 19) - 9;
            big[i]   = 255;
        end
        imp_exp = '{1, 2, 1, 1, 2, 4, 2, 2, 1, 2, 1, 1, 1, 2, 1, 1};

        reset = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        load(zeros);
        tick();
        tick();
        check("rst_in_ready", in_ready15, 0);
        check("rst_out_valid", out_valid15, 0);
        check("rst_tr0", tr15[0], 0);
        reset = 1'b0;
        tick();
        check("idle_in_ready", in_ready15, 1);

        // All-zero block and latency.
        load(zeros);
        accept();
        wait_done(1, cyc);
        check("latency", cyc, 9);
        check_block("zero", zeros);
        release_block();

        // All-ones block with backpressure; in_valid ignored while busy.
        load(ones);
        accept();
        wait_done(1, cyc);
        check("ones_latency", cyc, 9);
        exp = zeros;
        exp[0] = 16;
        check_block("ones", exp);
        load(ramp);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", out_valid15, 1);
            check("bp_in_ready", in_ready15, 0);
            check("bp_tr0", tr15[0], 16);
            check("bp_tr5", tr15[5], 0);
        end
        out_ready = 1'b1;
        tick();
        check("sim_out_valid", out_valid15, 0);
        check("sim_in_ready", in_ready15, 1);
        check("sim_tr0_held", tr15[0], 16);
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        check("idle_in_ready2", in_ready15, 1);

        // Impulse block.
        load(imp);
        accept();
        wait_done(1, cyc);
        check_block("impulse", imp_exp);
        release_block();

        // enable low for 3 cycles during ROW.
        load(ramp);
        accept();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("en_low_in_ready", in_ready15, 0);
            check("en_low_out_valid", out_valid15, 0);
        end
        enable = 1'b1;
        wait_done(4, cyc);
        check("en_latency", cyc, 12);
        model(ramp, exp);
        check_block("ramp", exp);
        enable = 1'b0;
        out_ready = 1'b1;
        tick();
        check("en_low_done_hold", out_valid15, 1);
        enable = 1'b1;
        tick();
        check("en_high_release", out_valid15, 0);
        out_ready = 1'b0;

        // Reset during COL, then a fresh block.
        load(ramp);
        accept();
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        reset = 1'b1;
        tick();
        check("midrst_out_valid", out_valid15, 0);
        check("midrst_in_ready", in_ready15, 0);
        check("midrst_tr0", tr15[0], 0);
        reset = 1'b0;
        tick();
        check("midrst_idle", in_ready15, 1);
        load(ramp2);
        accept();
        wait_done(1, cyc);
        check("ramp2_latency", cyc, 9);
        model(ramp2, exp);
        check_block("ramp2", exp);
        release_block();

        // Narrowing: 255 everywhere on both widths.
        load(big);
        accept();
        wait_done(1, cyc);
        check("big15_tr0", tr15[0], 4080);
        check("big15_tr1", tr15[1], 0);
        check("big15_tr15", tr15[15], 0);
        check("big11_valid", out_valid11, 1);
`ifdef FWDTRAN_SAT_EN
        exp11 = 2047;
`else
        exp11 = -16;
`endif
        check("big11_tr0", tr11[0], exp11);
        check("big11_tr4", tr11[4], 0);
        check("big11_tr10", tr11[10], 0);
        release_block();

        // Back-to-back blocks with in_valid held high.
        load(imp);
        acc_q.delete();
        out_ready = 1'b1;
        in_valid = 1'b1;
        n = 0;
        while (acc_q.size() < 2 && n < 60) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        check("b2b_accepts", acc_q.size(), 2);
        if (acc_q.size() >= 2) begin
            check("b2b_spacing", acc_q[1] - acc_q[0], 10);
        end
        check_block("b2b_first", imp_exp);
        wait_done(1, cyc);
        check("b2b_latency", cyc, 9);
        check_block("b2b_second", imp_exp);
        tick();
        check("b2b_out_valid", out_valid15, 0);
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
